// File: rtl/up_loader_if.sv
// Host-side bundle of the program-image loader: byte write stream, load
// control/status and the readback stream returned from the core.
interface up_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              wr_valid;
    logic [7:0]        wr_data;
    logic              wr_ready;
    logic              start;
    logic              clear;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              rb_valid;
    logic [7:0]        rb_data;

    // wr_*: a byte moves on an edge where wr_valid && wr_ready; wr_data is held
    // while wr_valid waits. rb_*: no backpressure, rb_data is valid only with rb_valid.
    modport master (
        output wr_valid, wr_data, start, clear,
        input  wr_ready, count, busy, done, rb_valid, rb_data
    );

    modport slave (
        input  wr_valid, wr_data, start, clear,
        output wr_ready, count, busy, done, rb_valid, rb_data
    );
endinterface

// File: rtl/up_loader.sv
// Buffers a 2^ADDR_W-byte program image from the host and shifts it into
// up_core highest address first, returning the core's outgoing bytes.
module up_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    up_loader_if.slave  bus,
    output logic        core_load,
    output logic [7:0]  core_mem_in,
    input  logic [7:0]  core_mem_out,
    output logic [1:0]  state_dbg
);
    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_READY = 2'd1,
        S_PUSH  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [7:0]          mem_in_q;
    logic                done_q, done_d;
    logic                rb_valid_q;
    logic [7:0]          rb_data_q;
    logic [7:0]          mem [DEPTH];

    logic                wr_en;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        k_d     = k_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = LAST;
        unique case (state_q)
            S_FILL: begin
                if (bus.clear) begin
                    count_d = '0;
                end else if (bus.wr_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_d == FULL) state_d = S_READY;
                end
            end
            S_READY: begin
                if (bus.clear) begin
                    count_d = '0;
                    state_d = S_FILL;
                end else if (bus.start) begin
                    state_d = S_PUSH;
                    k_d     = '0;
                    rd_en   = 1'b1;
                    rd_addr = LAST;
                end
            end
            S_PUSH: begin
                // k_q is the byte on core_mem_in now; fetch the next one so
                // the output advances on every edge.
                if (k_q == LAST) begin
                    state_d = S_READY;
                    done_d  = 1'b1;
                end else begin
                    k_d     = k_q + 1'b1;
                    rd_en   = 1'b1;
                    rd_addr = ~k_d;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FILL;
            count_q    <= '0;
            k_q        <= '0;
            mem_in_q   <= '0;
            done_q     <= 1'b0;
            rb_valid_q <= 1'b0;
            rb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            k_q        <= k_d;
            mem_in_q   <= rd_en ? mem[rd_addr] : 8'h00;
            done_q     <= done_d;
            rb_valid_q <= core_load;
            if (core_load) rb_data_q <= core_mem_out;
        end
    end

    // Image storage survives reset and clear; only count says what is valid.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[count_q[ADDR_W-1:0]] <= bus.wr_data;
    end

    assign core_load    = (state_q == S_PUSH);
    assign core_mem_in  = mem_in_q;
    assign state_dbg    = state_q;
    assign bus.wr_ready = (state_q == S_FILL);
    assign bus.count    = count_q;
    assign bus.busy     = core_load;
    assign bus.done     = done_q;
    assign bus.rb_valid = rb_valid_q;
    assign bus.rb_data  = rb_data_q;
endmodule

// File: doc/up_loader.md
# up_loader

Program-image loader that sits in front of `up_core`, driving the other end of its load interface. A host pushes a 256-byte program image into an internal buffer over a valid/ready byte stream; on `start` the block raises `core_load` and presents the image on `core_mem_in`, one byte per clock, highest address first. Bytes the core shifts out on `core_mem_out` during the load are returned on a readback stream.

## Interface
- `ADDR_W`, default 8: image depth is 2^ADDR_W bytes (DEPTH = 256 at default).
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `wr_valid` in 1: host byte valid.
- `wr_data` in 8: host byte. Bytes are written to ascending buffer addresses 0..DEPTH-1.
- `wr_ready` out 1: buffer accepts a byte this cycle.
- `start` in 1: request a load of the buffered image into the core.
- `clear` in 1: discard the buffered image (count to 0).
- `count` out ADDR_W+1: bytes currently buffered, 0..DEPTH.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse at the end of a load.
- `core_load` out 1: to `up_core.load`.
- `core_mem_in` out 8: to `up_core.mem_in`.
- `core_mem_out` in 8: from `up_core.mem_out`.
- `rb_valid` out 1: readback byte valid. No backpressure.
- `rb_data` out 8: readback byte.

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- States: FILL, READY, PUSH. A DONE pulse is emitted on the PUSH→READY transition.
- FILL
  - `wr_ready` = 1.
  - A `wr_valid` handshake writes `wr_data` to buf[count], then count+1.
  - When count reaches DEPTH, go to READY.
- READY
  - `wr_ready` = 0; extra host bytes are dropped.
  - `start` = 1: go to PUSH and clear the push index k to 0.
  - `clear` = 1: count = 0, go to FILL.
- PUSH
  - `core_load` = 1 and `busy` = 1 for exactly DEPTH cycles.
  - In push cycle k (0-based), `core_mem_in` = buf[DEPTH-1-k]. The first byte is buf[255] and the last is buf[0].
  - After cycle DEPTH-1: go to READY and pulse `done`.
  - The image is retained, so a further `start` reloads the same image without refilling.
- Readback
  - On every clock edge where `core_load` = 1, sample `core_mem_out` into `rb_data` and assert `rb_valid` in the following cycle.
  - Exactly DEPTH pulses per load.
- Outside PUSH, `core_mem_in` = 0 and `core_load` = 0.
- Precedence
  - `clear` beats `start` and beats a `wr_valid` in the same cycle.
  - `start` in FILL is ignored; it is not remembered.
  - `start` and `clear` during PUSH are ignored. `wr_ready` = 0 during PUSH.
- Reset
  - Outputs on reset: count = 0, state FILL, `wr_ready` = 1, `busy` = 0, `done` = 0, `core_load` = 0, `core_mem_in` = 0, `rb_valid` = 0, `rb_data` = 0.
  - Buffer RAM contents are not cleared.
  - Reset during PUSH drops `core_load` on the next edge. No `done` pulse and no further `rb_valid`.
- Width rules
  - Push index is ADDR_W bits.
  - `count` is ADDR_W+1 bits so that DEPTH is representable.
  - No wrap: writes are blocked at count = DEPTH.

## Timing
- Write handshake: byte accepted on an edge with `wr_valid` & `wr_ready`. `count` updates on that same edge.
- `wr_ready` falls in the cycle after the DEPTH-th byte is accepted.
- `start` is sampled high on edge E in READY. From edge E onward, `core_load` = 1 and `core_mem_in` = buf[DEPTH-1]. Latency is 1 cycle.
- Buffer read address is prefetched so that `core_mem_in` changes on every edge of PUSH with no bubbles.
- `core_load` is high for DEPTH consecutive cycles and falls on edge E+DEPTH. `done` = 1 for the cycle following edge E+DEPTH.
- `rb_valid` is high for cycles E+1 .. E+DEPTH, covering DEPTH pulses. The final pulse coincides with `done`.
- Minimum start-to-start period: DEPTH+1 cycles. `start` is accepted again in the `done` cycle.

## Test plan
- Fill: reset, then stream bytes 0x00..0xFF with `wr_valid` held high. Required: `count` = 256, `wr_ready` = 0, state READY. A 257th byte leaves the buffer and `count` unchanged.
- Load: `start` 1 cycle. Required: `core_load` high exactly 256 cycles; `core_mem_in` sequence 0xFF, 0xFE, …, 0x00; `done` single pulse on the cycle after `core_load` falls; `busy` = `core_load`.
- Readback: bench models the core as a 256-stage byte shift register preloaded with 0xA5. Required: 256 `rb_valid` pulses, all `rb_data` = 0xA5. A second `start` then returns 0xFF..0x00.
- Guards: `start` at `count` = 100 does nothing. `clear` and `start` in the same cycle in READY leave `count` = 0, state FILL, `core_load` = 0.
- Throttled host: `wr_valid` toggles every other cycle. Required: all 256 bytes are written in order and push order is still reversed.
- Reset mid-push: assert `rst` at push cycle 50. Required: `core_load` = 0 on the next edge, `count` = 0, no `done` pulse, no further `rb_valid`; after refill, the load behaves normally.
